dmem_byte_lane_ram: RTL and testbench

//  Parametrised, byte-addressable data memory for the 64-bit RISC-V pipeline (MEM stage).
//  - Supports all RV64 load/store widths via funct3, with sign/zero extension and byte-enable writes.
//  - Registered read pipeline with valid/ready handshake; optional clear-on-reset state machine.
//  - Debug word-view port for bubble-sort result observation.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_load_align.sv | 28 ++
 rtl/dmem_byte_lane_ram.sv | 167 ++++++++++++++++
 tb/tb_dmem_byte_lane_ram.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory.
//   F3_*        RV64 load/store funct3 encodings
//   size_bytes  access size in bytes from funct3[1:0]
//   state_t     clear/ready state machine encoding
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] f);
        return 4'd1 << f;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data extraction: picks the low 1/2/4/8 bytes of an 8-byte window that
// already starts at the request address, then sign- or zero-extends to 64 bits.
//   window  in   64  bytes addr..addr+7, little-endian
//   funct3  in   3   load type
//   rdata   out  64  extended load value (0 for undefined funct3)
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [63:0] window,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata
);

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{56{window[7]}},  window[7:0]};
            F3_H:    rdata = {{48{window[15]}}, window[15:0]};
            F3_W:    rdata = {{32{window[31]}}, window[31:0]};
            F3_D:    rdata = window;
            F3_BU:   rdata = {56'b0, window[7:0]};
            F3_HU:   rdata = {48'b0, window[15:0]};
            F3_WU:   rdata = {32'b0, window[31:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_byte_lane_ram.sv
// Byte-addressable data memory for the RV64 MEM stage.
// Build option: MISALIGN_TRAP_EN -- when defined, accesses whose address is
// not a multiple of the access size are rejected with rsp_err.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready low while initialising)
//   req_we, req_funct3   store/load select and RV64 width/extension code
//   req_addr, req_wdata  byte address and store data (low bytes used)
//   rsp_valid            one pulse per accepted request, READ_LATENCY later
//   rsp_rdata, rsp_err   extended load data / rejected access flag
//   init_done            high once the memory is ready for requests
//   dbg_idx, dbg_word    combinational doubleword view for debug
module dmem_byte_lane_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES    = 64,
    parameter int ADDR_W         = 64,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int IDX_W = (DEPTH_BYTES > 8) ? $clog2(DEPTH_BYTES / 8) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done,
    input  logic [IDX_W-1:0]  dbg_idx,
    output logic [63:0]       dbg_word
);

    localparam int AW  = $clog2(DEPTH_BYTES);
    localparam int NDW = DEPTH_BYTES / 8;

    logic [7:0] mem [DEPTH_BYTES];

    state_t           state, state_next;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_en;

    // ---------------- init / ready FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_en     = 1'b0;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        case (state)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_en = 1'b1;
                    if (clr_idx == IDX_W'(NDW - 1)) state_next = ST_IDLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       clr_idx <= '0;
        else if (clr_en) clr_idx <= clr_idx + 1'b1;
    end

    // ---------------- request decode ----------------
    logic [3:0]      size;
    logic [ADDR_W:0] last_addr;
    logic            err_range, err_f3, err_align, acc_err, accept;
    logic [AW:0]     byte_idx [8];
    logic [63:0]     window, ld_data;

    always_comb begin
        size = size_bytes(req_funct3[1:0]);
        // One extra bit keeps addresses near the top of ADDR_W from wrapping
        // back into low memory.
        last_addr = {1'b0, req_addr} + (ADDR_W + 1)'(size) - (ADDR_W + 1)'(1);
        err_range = last_addr >= (ADDR_W + 1)'(DEPTH_BYTES);
        err_f3    = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
        err_align = (req_addr[2:0] & 3'(size - 4'd1)) != 3'b000;
`else
        err_align = 1'b0;
`endif
        acc_err = err_range | err_f3 | err_align;
        accept  = req_valid & req_ready;

        // Bytes past the end of memory read as zero; they only matter when
        // the access is out of range, which is reported as an error anyway.
        window = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            byte_idx[i] = {1'b0, req_addr[AW-1:0]} + (AW + 1)'(i);
            if (!byte_idx[i][AW]) window[8*i +: 8] = mem[byte_idx[i][AW-1:0]];
        end
    end

    dmem_load_align u_align (
        .window (window),
        .funct3 (req_funct3),
        .rdata  (ld_data)
    );

    // ---------------- storage ----------------
    // Contents are deliberately not reset so CLEAR_ON_RESET=0 keeps them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en) begin
                for (int unsigned i = 0; i < 8; i++)
                    mem[AW'(int'(clr_idx) * 8 + i)] <= '0;
            end else if (accept && req_we && !acc_err) begin
                for (int unsigned i = 0; i < 8; i++)
                    if (4'(i) < size && !byte_idx[i][AW])
                        mem[byte_idx[i][AW-1:0]] <= req_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- response pipeline ----------------
    logic        pipe_v [READ_LATENCY];
    logic        pipe_e [READ_LATENCY];
    logic [63:0] pipe_d [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_e[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_e[0] <= accept & acc_err;
            pipe_d[0] <= (accept && !acc_err && !req_we) ? ld_data : '0;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign rsp_valid = pipe_v[READ_LATENCY-1];
    assign rsp_err   = pipe_e[READ_LATENCY-1];
    assign rsp_rdata = pipe_d[READ_LATENCY-1];

    // ---------------- debug view ----------------
    always_comb begin
        dbg_word = '0;
        for (int unsigned i = 0; i < 8; i++)
            dbg_word[8*i +: 8] = mem[AW'(int'(dbg_idx) * 8 + i)];
    end

endmodule

// File: tb/tb_dmem_byte_lane_ram.sv
// Self-checking bench for dmem_byte_lane_ram (DEPTH 64, READ_LATENCY 3,
// CLEAR_ON_RESET 1). Honours MISALIGN_TRAP_EN in its reference model.
module tb_dmem_byte_lane_ram;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;
    localparam int NDW   = DEPTH / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;
    logic [2:0]  dbg_idx = '0;
    logic [63:0] dbg_word;

    dmem_byte_lane_ram #(
        .DEPTH_BYTES    (DEPTH),
        .ADDR_W         (64),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done),
        .dbg_idx    (dbg_idx),
        .dbg_word   (dbg_word)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic        err;
        logic [63:0] data;
    } exp_t;

    logic [7:0] mm [DEPTH];
    exp_t       q [$];
    int         cycle     = 0;
    int         init_left = 0;
    bit         armed     = 0;
    int         total     = 0;
    int         bad       = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, output logic err, output logic [63:0] data);
        int unsigned sz;
        logic [64:0] last;
        sz   = 1 << f3[1:0];
        last = {1'b0, a} + 65'(sz) - 65'd1;
        err  = (last >= 65'(DEPTH)) || (we && f3[2]) || (!we && f3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
        err  = err || ((a % 64'(sz)) != 0);
`endif
        data = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(sz); i++) mm[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < int'(sz); i++) data[8*i +: 8] = mm[int'(a) + i];
                if (!f3[2] && sz < 8 && data[8*sz-1])
                    data = data | ~((64'd1 << (8*sz)) - 64'd1);
            end
        end
    endtask

    task automatic check_outputs();
        if (!armed) return;
        chk("req_ready", {63'b0, req_ready}, {63'b0, init_left == 0});
        chk("init_done", {63'b0, init_done}, {63'b0, init_left == 0});
        if (q.size() > 0 && q[0].due == cycle) begin
            chk("rsp_valid", {63'b0, rsp_valid}, 64'd1);
            chk("rsp_err", {63'b0, rsp_err}, {63'b0, q[0].err});
            chk("rsp_rdata", rsp_rdata, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", {63'b0, rsp_valid}, 64'd0);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance model at the edge.
    task automatic cyc(input logic v, input logic we, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic rst);
        logic        e;
        logic [63:0] d;
        check_outputs();
        reset      = rst;
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        if (v && !rst && init_left == 0) begin
            model_access(we, f3, a, wd, e, d);
            q.push_back('{due: cycle + LAT, err: e, data: d});
        end
        @(posedge clk);
        cycle++;
        if (rst) begin
            q.delete();
            init_left = NDW;
            for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
            armed = 1;
        end else if (init_left > 0) begin
            init_left--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [63:0] a);
        cyc(1'b1, 1'b0, f3, a, 64'd0, 1'b0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        cyc(1'b1, 1'b1, f3, a, wd, 1'b0);
    endtask

    task automatic count_init(input string tag);
        int lows = 0;
        for (int k = 0; k < 20 && req_ready !== 1'b1; k++) begin
            lows++;
            idle(1);
        end
        chk(tag, 64'(lows), 64'd8);
    endtask

    task automatic check_dbg(input string tag);
        for (int i = 0; i < NDW; i++) begin
            logic [63:0] expw;
            dbg_idx = 3'(i);
            #1;
            for (int b = 0; b < 8; b++) expw[8*b +: 8] = mm[i*8 + b];
            chk(tag, dbg_word, expw);
        end
    endtask

    initial begin
        @(negedge clk);
        // 1: reset then clear sequence
        cyc(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b1);
        cyc(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 1'b1);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_err", {63'b0, rsp_err}, 64'd0);
        chk("rst_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_ready", {63'b0, req_ready}, 64'd0);
        chk("rst_init_done", {63'b0, init_done}, 64'd0);
        count_init("init_cycles");
        check_dbg("dbg_after_clear");

        // 2: doubleword store/load
        st(3'b011, 64'd0, 64'h1122334455667788);
        ld(3'b011, 64'd0);
        idle(LAT);

        // 3: byte store, signed/unsigned byte and half loads
        st(3'b000, 64'd8, 64'h80);
        ld(3'b000, 64'd8);
        ld(3'b100, 64'd8);
        ld(3'b001, 64'd8);
        idle(LAT);

        // 4: range errors, including a near-top address that must not wrap
        st(3'b011, 64'd56, 64'hA5A5_5A5A_DEAD_BEEF);
        ld(3'b011, 64'd60);
        st(3'b010, 64'd62, 64'h0102_0304);
        ld(3'b011, 64'hFFFF_FFFF_FFFF_FFFC);
        st(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h77);
        st(3'b100, 64'd16, 64'h1);
        ld(3'b111, 64'd16);
        idle(LAT);

        // 5: misaligned word load
        ld(3'b010, 64'd2);
        ld(3'b110, 64'd3);
        idle(LAT);
        check_dbg("dbg_directed");

        // 6: back-to-back loads, reset mid-stream drops them
        ld(3'b011, 64'd0);
        ld(3'b010, 64'd8);
        ld(3'b000, 64'd56);
        cyc(1'b1, 1'b0, 3'b011, 64'd0, 64'd0, 1'b1);
        count_init("init_rerun");
        check_dbg("dbg_after_rerun");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [63:0] a;
            logic [63:0] wd;
            if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else                            a = 64'($urandom_range(0, 70));
            wd = {$urandom, $urandom};
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), a, wd, 1'b0);
        end
        idle(LAT + 1);
        check_dbg("dbg_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
